spm_seq: RTL and testbench

SPM_SEQ -- requirements
Module: spm_seq

---
 rtl/spm_pkg.sv | 18 +
 rtl/spm_seq_if.sv | 26 ++
 rtl/spm_prod_sipo.sv | 24 ++
 rtl/spm_seq.sv | 118 +++++++++++
 tb/tb_spm_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier sequencer.
package spm_pkg;

  localparam int SPM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } spm_seq_state_t;

  // ceil(log2(n)), never less than one bit
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spm_seq_if.sv
// Operand/result handshake bundle between a client and spm_seq.
interface spm_seq_if
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid, mc, mp, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, mc, mp, out_ready,
    output in_ready, out_valid, prod
  );

endinterface

// File: rtl/spm_prod_sipo.sv
// Product capture register: one serial bit written per enabled cycle at idx.
module spm_prod_sipo
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH,
  parameter int IW    = cnt_bits(2*WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IW-1:0]      idx,
  input  logic               bit_in,
  output logic [2*WIDTH-1:0] prod
);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
    end else if (we) begin
      prod[idx] <= bit_in;
    end
  end

endmodule

// File: rtl/spm_seq.sv
// Bit-serial multiply sequencer: latches an operand pair, streams the multiplier
// LSB first into an external serial-parallel multiplier and collects the product.
module spm_seq
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  spm_seq_if.slave         bus,
  output logic             spm_rst,
  output logic [WIDTH-1:0] spm_x,
  output logic             spm_y,
  input  logic             spm_p
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // CLEAR | one-cycle spm_rst pulse, counter cleared
  // RUN   | multiplier bits streamed out, product bits captured
  // DONE  | product held on prod until the consumer takes it

  localparam int RUN_LEN = 2*WIDTH + LAT;
  localparam int CW      = cnt_bits(RUN_LEN);
  localparam int IW      = cnt_bits(2*WIDTH);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(RUN_LEN - 1);
  localparam cnt_t CNT_LAT  = cnt_t'(LAT);
  localparam cnt_t CNT_W    = cnt_t'(WIDTH);

  spm_seq_state_t     state, state_nxt;
  cnt_t               cnt;
  logic [WIDTH-1:0]   mc_q, mp_q, mp_sh;
  logic               xfer, run, sipo_we;
  logic [IW-1:0]      sipo_idx;
  logic [2*WIDTH-1:0] prod_q;

  assign run  = (state == RUN);
  assign xfer = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    spm_rst       = rst;
    spm_x         = '0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst) state_nxt = CLEAR;
      end
      CLEAR: begin
        spm_rst   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        spm_x = mc_q;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = !rst;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // counter parks at its last value after RUN; it is only restarted in CLEAR
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      mc_q <= '0;
      mp_q <= '0;
    end else begin
      if (xfer) begin
        mc_q <= bus.mc;
        mp_q <= bus.mp;
      end
      if (state == CLEAR) begin
        cnt <= '0;
      end else if (run && (cnt != CNT_LAST)) begin
        cnt <= cnt + cnt_t'(1);
      end
    end
  end

  assign mp_sh = mp_q >> cnt;
  assign spm_y = run && (cnt < CNT_W) && mp_sh[0];

  assign sipo_we  = run && (cnt >= CNT_LAT);
  assign sipo_idx = IW'(cnt - CNT_LAT);

  spm_prod_sipo #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_prod (
    .clk    (clk),
    .rst    (rst),
    .we     (sipo_we),
    .idx    (sipo_idx),
    .bit_in (spm_p),
    .prod   (prod_q)
  );

  assign bus.prod = prod_q;

endmodule

// File: tb/tb_spm_seq.sv
// Self-checking bench for spm_seq (WIDTH=8, LAT=1) with a behavioural one-cycle spm.
module tb_spm_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spm_rst;
  logic [W-1:0] spm_x;
  logic         spm_y;
  logic         spm_p = 1'b0;

  spm_seq_if #(.WIDTH(W)) bus ();

  spm_seq #(
    .WIDTH (W),
    .LAT   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .spm_rst (spm_rst),
    .spm_x   (spm_x),
    .spm_y   (spm_y),
    .spm_p   (spm_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // spm model: accumulates x*y_k<<k; bit k is final once y bit k is seen, emitted next cycle
  logic [63:0] acc = '0;
  logic [63:0] nacc;
  logic [5:0]  k = '0;

  always_comb nacc = acc + (spm_y ? (64'(spm_x) << k) : 64'd0);

  always @(posedge clk) begin
    if (spm_rst) begin
      acc   <= '0;
      k     <= '0;
      spm_p <= 1'b0;
    end else begin
      acc   <= nacc;
      spm_p <= nacc[k];
      if (k != 6'd63) k <= k + 6'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  // drive a pair and wait for the IDLE cycle that takes it; returns at CLEAR+#1
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit hold,
                      output bit ok, output int tx);
    ok = 1'b0;
    tx = 0;
    @(posedge clk); #1;
    bus.mc = a;
    bus.mp = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        tx = cyc;
        break;
      end
    end
    if (ok) sb.push_back(16'(a) * 16'(b));
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // wait for out_valid, counting spm_rst and in_ready cycles seen on the way
  task automatic wait_out(output bit ok, output int t, output int n_rst, output int n_rdy);
    ok = 1'b0;
    t = 0;
    n_rst = 0;
    n_rdy = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      if (spm_rst) n_rst++;
      if (bus.in_ready) n_rdy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (spm_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_spm_rst: got %b required 1", spm_rst);
    end
    checks++;
    if (bus.prod !== 16'd0 || spm_x !== 8'd0 || spm_y !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: prod=%0d spm_x=%0d spm_y=%b required 0 0 0", bus.prod, spm_x, spm_y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || spm_rst !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b spm_rst=%b out_valid=%b required 1 0 0",
               bus.in_ready, spm_rst, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    bit ok, got;
    int tx, t, nr, ny;
    logic [15:0] exp;
    bus.out_ready = 1'b1;
    send(8'd3, 8'd5, 1'b0, ok, tx);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_accept: in_ready=0 required 1");
    end
    wait_out(got, t, nr, ny);
    checks++;
    if (!got || sb.size() == 0) begin
      errors++;
      $display("FAIL basic_out_valid: timed out, queue=%0d", sb.size());
    end else begin
      exp = sb.pop_front();
      checks++;
      if (bus.prod !== exp) begin
        errors++;
        $display("FAIL basic_prod: got %0d required %0d", bus.prod, exp);
      end
      checks++;
      if (t - tx !== 19) begin
        errors++;
        $display("FAIL basic_latency: got %0d required 19", t - tx);
      end
      checks++;
      if (nr !== 1 || ny !== 0) begin
        errors++;
        $display("FAIL basic_busy: spm_rst cycles=%0d in_ready cycles=%0d required 1 0", nr, ny);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return_idle: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_max();
    bit ok, got;
    int tx, t, nr, ny;
    logic [15:0] exp;
    logic [7:0] av[2];
    logic [7:0] bv[2];
    av[0] = 8'd255; bv[0] = 8'd255;
    av[1] = 8'd0;   bv[1] = 8'd200;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(av[i], bv[i], 1'b0, ok, tx);
      wait_out(got, t, nr, ny);
      checks++;
      if (!ok || !got || sb.size() == 0) begin
        errors++;
        $display("FAIL max_%0d_handshake: accepted=%b out_valid=%b", i, ok, got);
      end else begin
        exp = sb.pop_front();
        checks++;
        if (bus.prod !== exp) begin
          errors++;
          $display("FAIL max_%0d_prod: got %0d required %0d", i, bus.prod, exp);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok, got;
    int tx, t, nr, ny, bad;
    logic [15:0] exp, held;
    bus.out_ready = 1'b0;
    send(8'd165, 8'd60, 1'b0, ok, tx);
    wait_out(got, t, nr, ny);
    checks++;
    if (!ok || !got || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_handshake: accepted=%b out_valid=%b", ok, got);
    end else begin
      exp = sb.pop_front();
      held = bus.prod;
      checks++;
      if (held !== exp) begin
        errors++;
        $display("FAIL bp_prod: got %0d required %0d", held, exp);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.prod !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            spm_x !== 8'd0 || spm_y !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL bp_hold: %0d cycles with prod/in_ready/out_valid/spm outputs disturbed, required 0", bad);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_busy();
    bit ok, got;
    int tx, t, nr, ny, extra;
    logic [15:0] exp;
    bus.out_ready = 1'b1;
    send(8'd9, 8'd11, 1'b0, ok, tx);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.mc = 8'd7;
    bus.mp = 8'd7;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_ready: got %b required 0", bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_out(got, t, nr, ny);
    checks++;
    if (!ok || !got || sb.size() == 0) begin
      errors++;
      $display("FAIL busy_handshake: accepted=%b out_valid=%b", ok, got);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (bus.prod !== exp || t - tx !== 19) begin
        errors++;
        $display("FAIL busy_prod: got %0d latency %0d required %0d latency 19", bus.prod, t - tx, exp);
      end
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_extra_out: %0d extra out_valid cycles, required 0", extra);
    end
  endtask

  task automatic test_midrun_reset();
    bit ok, got;
    int tx, t, nr, ny, extra;
    logic [15:0] exp;
    bus.out_ready = 1'b1;
    send(8'd200, 8'd100, 1'b0, ok, tx);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (spm_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_in_reset: spm_rst=%b in_ready=%b out_valid=%b required 1 0 0",
               spm_rst, bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.prod !== 16'd0 || spm_rst !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: in_ready=%b prod=%0d spm_rst=%b required 1 0 0",
               bus.in_ready, bus.prod, spm_rst);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midrun_no_out: %0d out_valid cycles, required 0", extra);
    end
    send(8'd12, 8'd10, 1'b0, ok, tx);
    wait_out(got, t, nr, ny);
    checks++;
    if (!ok || !got || sb.size() == 0) begin
      errors++;
      $display("FAIL midrun_after_handshake: accepted=%b out_valid=%b", ok, got);
    end else begin
      exp = sb.pop_front();
      checks++;
      if (bus.prod !== exp || t - tx !== 19 || nr !== 1) begin
        errors++;
        $display("FAIL midrun_after_prod: got %0d latency %0d spm_rst %0d required %0d 19 1",
                 bus.prod, t - tx, nr, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    bit ok, got;
    int tx, t, nr, ny, prev;
    logic [15:0] exp;
    logic [7:0] a, b;
    bus.out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 50; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b, 1'b1, ok, tx);
      wait_out(got, t, nr, ny);
      checks++;
      if (!ok || !got || sb.size() == 0) begin
        errors++;
        $display("FAIL stream_%0d_handshake: accepted=%b out_valid=%b", i, ok, got);
        break;
      end
      exp = sb.pop_front();
      checks++;
      if (bus.prod !== exp || t - tx !== 19) begin
        errors++;
        $display("FAIL stream_%0d_prod: %0d*%0d got %0d latency %0d required %0d latency 19",
                 i, a, b, bus.prod, t - tx, exp);
      end
      if (i > 0) begin
        checks++;
        if (t - prev !== 20) begin
          errors++;
          $display("FAIL stream_%0d_period: got %0d required 20", i, t - prev);
        end
      end
      prev = t;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() !== 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: queue=%0d out_valid=%b required 0 0", sb.size(), bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mc        = '0;
    bus.mp        = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_busy();
    test_midrun_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
